iiitb_wm_prog: RTL and testbench
================================

Name: iiitb_wm_prog

Overview:
Programmable washing-machine controller. It is the parametrised successor to the fixed-sequence washer FSM and sits behind user_proj_example, with inputs from io_in and outputs to io_out.
- Internal down-counters replace the external cycle and spin timeout inputs.
- The rinse count is configurable.
- New behaviour: a pause input, and a fill/drain watchdog that enters a FAULT state.
- Configuration is latched at start, so a programme runs unaffected by later input changes.

Parameters:
TIMER_W, 16, width of the wash/rinse/spin duration fields and of the phase timer
RINSE_W, 2, width of cfg_rinses and rinse_cnt (up to 2^RINSE_W-1 rinses)
FILL_TIMEOUT, 1000, maximum cycles allowed in FILL or DRAIN before FAULT (1..2^TIMER_W-1)

Ports:
clk  in  1  system clock (driven from wb_clk_i)
reset_n  in  1  asynchronous active-low reset
door_close  in  1  door sensor, 1 = closed
start  in  1  programme request, level
pause  in  1  hold request, level
filled  in  1  water-level-full sensor
detergent_added  in  1  detergent sensor
drained  in  1  drum-empty sensor
cfg_wash_time  in  TIMER_W  soap-wash duration, cycles-1
cfg_rinse_time  in  TIMER_W  each rinse agitation duration, cycles-1
cfg_spin_time  in  TIMER_W  spin duration, cycles-1
cfg_rinses  in  RINSE_W  number of rinse passes
door_lock  out  1  door latch
motor_on  out  1  drum motor
fill_valve_on  out  1  inlet valve
drain_valve_on  out  1  drain valve
done  out  1  programme complete
soap_wash  out  1  soap phase active
water_wash  out  1  rinse phase active
fault  out  1  watchdog fault
state_o  out  3  current state encoding
rinse_cnt  out  RINSE_W  rinses started

Behaviour:
- Reset is asynchronous (reset_n=0). It forces IDLE and clears all outputs, counters, the phase flag and latched config. Reset mid-operation aborts immediately; there is no resume.
- All outputs are registered and updated on the same edge as the state register.
- States:
  - IDLE=0.
  - FILL=1.
  - DETERGENT=2.
  - AGITATE=3.
  - DRAIN=4.
  - SPIN=5.
  - DONE=6.
  - FAULT=7.
- IDLE: all outputs 0. If start and door_close, latch the cfg_* inputs, set rinse_cnt=0 and phase=soap, then go to FILL.
- FILL: outputs door_lock=1, fill_valve_on=1. When filled=1:
  - phase soap: go to DETERGENT.
  - phase rinse: go to AGITATE and load the timer with the latched rinse time.
- DETERGENT: outputs door_lock=1, soap_wash=1. When detergent_added=1, go to AGITATE and load the timer with the latched wash time.
- AGITATE: outputs door_lock=1, motor_on=1. The timer decrements each cycle and the state exits to DRAIN in the cycle the timer equals 0, so agitation lasts cfg+1 cycles.
- DRAIN: outputs door_lock=1, drain_valve_on=1. When drained=1:
  - if rinse_cnt < latched cfg_rinses: increment rinse_cnt, set phase=rinse, go to FILL.
  - otherwise: load the timer with the spin time and go to SPIN.
  - cfg_rinses=0 goes straight to SPIN after the soap drain.
- SPIN: outputs door_lock=1, motor_on=1, drain_valve_on=1. Exits to DONE when the timer equals 0.
- DONE: done=1, door_lock=0, all other actuators 0. Returns to IDLE when start=0, so one start pulse never runs two programmes.
- soap_wash=1 from DETERGENT entry until DONE/IDLE. water_wash=1 while phase=rinse.
- Pause (pause=1) in FILL, DETERGENT, AGITATE, DRAIN or SPIN:
  - motor and valves off, door_lock stays 1.
  - phase timer and watchdog frozen, no state transition.
  - pause has priority over a simultaneous timer==0 or sensor event.
  - pause is ignored in IDLE, DONE and FAULT.
- Watchdog:
  - loads FILL_TIMEOUT on entry to FILL or DRAIN and decrements each unpaused cycle.
  - reaching 0 without the exit sensor enters FAULT.
  - a sensor asserted in the same cycle the watchdog reaches 0 wins (normal transition).
- FAULT:
  - fault=1, drain_valve_on=1, door_lock=1, others 0.
  - once drained=1: drain_valve_on=0, door_lock=0.
  - leaves to IDLE when drained=1 and start=0; fault clears on exit.
- door_close falling while locked is ignored; door_lock guarantees closure.
- Config input changes after the start latch have no effect until the next programme.

Decomposition:
- Package iiitb_wm_pkg holds the state encodings (3-bit localparams) and the phase encoding.
- One sub-module, iiitb_wm_timer: a loadable down-counter with TIMER_W width, load/value/hold inputs and a zero flag. It is instanced twice, as the phase timer and as the watchdog.
- The FSM, config latch and output register stay in iiitb_wm_prog.

Test Plan:
- Full programme, cfg_wash=5, cfg_rinse=3, cfg_spin=4, cfg_rinses=2, sensors pulsed promptly:
  - visited states: FILL, DET, AGI (motor 6 cycles), DRAIN, then FILL, AGI (4), DRAIN twice, then SPIN (5 cycles motor+drain), DONE.
  - rinse_cnt=2, done=1 until start drops.
- cfg_rinses=0 -> DRAIN goes directly to SPIN; water_wash never 1; rinse_cnt stays 0.
- pause=1 for 10 cycles while AGITATE timer=3 -> motor_on=0 and state_o=3 held; after release, total motor-on cycles remain 6.
- FILL_TIMEOUT=8, filled held 0:
  - FAULT after 9 cycles in FILL; fault=1, drain_valve_on=1.
  - drained=1 -> door_lock=0.
  - start=0 -> IDLE, fault=0.
- reset_n=0 mid-SPIN -> all outputs 0 asynchronously (same cycle); after release, state_o=0 and rinse_cnt=0.
- start=1 with door_close=0 -> stays IDLE.
- cfg_wash_time changed from 5 to 20 during AGITATE -> agitation still 6 cycles.

Source files
------------

// File: rtl/iiitb_wm_pkg.sv
// ---------------------------------------------------------------------------
// iiitb_wm_pkg
// Shared definitions for the programmable washing-machine controller:
// 3-bit state encodings (also exported on state_o), the wash-phase flag and a
// helper that identifies the pausable "working" states.
// ---------------------------------------------------------------------------
package iiitb_wm_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FILL      = 3'd1;
    localparam logic [2:0] ST_DETERGENT = 3'd2;
    localparam logic [2:0] ST_AGITATE   = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_SPIN      = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_FAULT     = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FILL      = ST_FILL,
        S_DETERGENT = ST_DETERGENT,
        S_AGITATE   = ST_AGITATE,
        S_DRAIN     = ST_DRAIN,
        S_SPIN      = ST_SPIN,
        S_DONE      = ST_DONE,
        S_FAULT     = ST_FAULT
    } state_e;

    typedef enum logic {
        PH_SOAP  = 1'b0,
        PH_RINSE = 1'b1
    } phase_e;

    // States in which pause is honoured and the door must stay locked.
    function automatic logic is_active(input state_e st);
        return (st == S_FILL) || (st == S_DETERGENT) || (st == S_AGITATE) ||
               (st == S_DRAIN) || (st == S_SPIN);
    endfunction

endpackage

// File: rtl/iiitb_wm_timer.sv
// ---------------------------------------------------------------------------
// iiitb_wm_timer
// Loadable down-counter that stops at zero. Used as the phase timer and as
// the fill/drain watchdog of iiitb_wm_prog.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (count cleared)
//   load_i   : load value_i this cycle (wins over hold_i)
//   value_i  : reload value
//   hold_i   : freeze the count
//   zero_o   : count is zero
// ---------------------------------------------------------------------------
module iiitb_wm_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    input  logic               hold_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (!hold_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/iiitb_wm_prog.sv
// ---------------------------------------------------------------------------
// iiitb_wm_prog
// Programmable washing-machine controller. A programme runs
// FILL -> DETERGENT -> AGITATE -> DRAIN, then cfg_rinses passes of
// FILL -> AGITATE -> DRAIN, then SPIN -> DONE. Durations and rinse count are
// latched when the programme starts. pause freezes the working states; a
// watchdog bounds time spent in FILL and DRAIN and escalates to FAULT.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   door_close, start      : door sensor, programme request (level)
//   pause                  : hold request (level)
//   filled, detergent_added, drained : process sensors
//   cfg_wash_time, cfg_rinse_time, cfg_spin_time : durations, cycles-1
//   cfg_rinses             : number of rinse passes
//   door_lock, motor_on, fill_valve_on, drain_valve_on : actuators
//   done, soap_wash, water_wash, fault : status flags
//   state_o, rinse_cnt     : current state encoding, rinses started
// All outputs are registered.
// ---------------------------------------------------------------------------
module iiitb_wm_prog
    import iiitb_wm_pkg::*;
#(
    parameter int TIMER_W      = 16,
    parameter int RINSE_W      = 2,
    parameter int FILL_TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               door_close,
    input  logic               start,
    input  logic               pause,
    input  logic               filled,
    input  logic               detergent_added,
    input  logic               drained,
    input  logic [TIMER_W-1:0] cfg_wash_time,
    input  logic [TIMER_W-1:0] cfg_rinse_time,
    input  logic [TIMER_W-1:0] cfg_spin_time,
    input  logic [RINSE_W-1:0] cfg_rinses,
    output logic               door_lock,
    output logic               motor_on,
    output logic               fill_valve_on,
    output logic               drain_valve_on,
    output logic               done,
    output logic               soap_wash,
    output logic               water_wash,
    output logic               fault,
    output logic [2:0]         state_o,
    output logic [RINSE_W-1:0] rinse_cnt
);

    localparam logic [TIMER_W-1:0] WD_LOAD = TIMER_W'(FILL_TIMEOUT);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [TIMER_W-1:0] wash_time_q, wash_time_d;
    logic [TIMER_W-1:0] rinse_time_q, rinse_time_d;
    logic [TIMER_W-1:0] spin_time_q, spin_time_d;
    logic [RINSE_W-1:0] rinses_q, rinses_d;
    logic [RINSE_W-1:0] rinse_cnt_q, rinse_cnt_d;
    logic               drained_seen_q, drained_seen_d;

    logic door_lock_q, door_lock_d;
    logic motor_q, motor_d;
    logic fill_q, fill_d;
    logic drain_q, drain_d;
    logic done_q, done_d;
    logic soap_q, soap_d;
    logic water_q, water_d;
    logic fault_q, fault_d;

    logic               paused;
    logic               ph_load, ph_zero;
    logic [TIMER_W-1:0] ph_value;
    logic               wd_load, wd_zero;

    // Pause only acts on working states; both timers freeze with it.
    assign paused = pause && is_active(state_q);

    iiitb_wm_timer #(.TIMER_W(TIMER_W)) u_phase_timer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (ph_load),
        .value_i (ph_value),
        .hold_i  (paused),
        .zero_o  (ph_zero)
    );

    iiitb_wm_timer #(.TIMER_W(TIMER_W)) u_watchdog (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .load_i  (wd_load),
        .value_i (WD_LOAD),
        .hold_i  (paused),
        .zero_o  (wd_zero)
    );

    // Next-state, config latch and counters.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        wash_time_d    = wash_time_q;
        rinse_time_d   = rinse_time_q;
        spin_time_d    = spin_time_q;
        rinses_d       = rinses_q;
        rinse_cnt_d    = rinse_cnt_q;
        drained_seen_d = 1'b0;
        ph_load        = 1'b0;
        ph_value       = wash_time_q;

        if (!paused) begin
            case (state_q)
                S_IDLE: begin
                    if (start && door_close) begin
                        wash_time_d  = cfg_wash_time;
                        rinse_time_d = cfg_rinse_time;
                        spin_time_d  = cfg_spin_time;
                        rinses_d     = cfg_rinses;
                        rinse_cnt_d  = '0;
                        phase_d      = PH_SOAP;
                        state_d      = S_FILL;
                    end
                end
                S_FILL: begin
                    // The sensor wins over a watchdog expiring in the same cycle.
                    if (filled) begin
                        if (phase_q == PH_RINSE) begin
                            ph_load  = 1'b1;
                            ph_value = rinse_time_q;
                            state_d  = S_AGITATE;
                        end else begin
                            state_d  = S_DETERGENT;
                        end
                    end else if (wd_zero) begin
                        state_d = S_FAULT;
                    end
                end
                S_DETERGENT: begin
                    if (detergent_added) begin
                        ph_load  = 1'b1;
                        ph_value = wash_time_q;
                        state_d  = S_AGITATE;
                    end
                end
                S_AGITATE: begin
                    if (ph_zero) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        if (rinse_cnt_q < rinses_q) begin
                            rinse_cnt_d = rinse_cnt_q + RINSE_W'(1);
                            phase_d     = PH_RINSE;
                            state_d     = S_FILL;
                        end else begin
                            ph_load  = 1'b1;
                            ph_value = spin_time_q;
                            state_d  = S_SPIN;
                        end
                    end else if (wd_zero) begin
                        state_d = S_FAULT;
                    end
                end
                S_SPIN: begin
                    if (ph_zero) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // Waiting for start to drop stops a held start relaunching.
                    if (!start) begin
                        state_d = S_IDLE;
                    end
                end
                S_FAULT: begin
                    // Once the drum is seen empty the door may unlock; this sticks.
                    drained_seen_d = drained_seen_q || drained;
                    if (drained && !start) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d == S_IDLE) begin
            phase_d     = PH_SOAP;
            rinse_cnt_d = '0;
        end
    end

    // Watchdog restarts whenever FILL or DRAIN is freshly entered.
    assign wd_load = (state_d != state_q) && ((state_d == S_FILL) || (state_d == S_DRAIN));

    // Output decode from the next state so outputs align with state_o.
    always_comb begin
        door_lock_d = 1'b0;
        motor_d     = 1'b0;
        fill_d      = 1'b0;
        drain_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            S_FILL: begin
                door_lock_d = 1'b1;
                fill_d      = !paused;
            end
            S_DETERGENT: begin
                door_lock_d = 1'b1;
            end
            S_AGITATE: begin
                door_lock_d = 1'b1;
                motor_d     = !paused;
            end
            S_DRAIN: begin
                door_lock_d = 1'b1;
                drain_d     = !paused;
            end
            S_SPIN: begin
                door_lock_d = 1'b1;
                motor_d     = !paused;
                drain_d     = !paused;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_FAULT: begin
                fault_d     = 1'b1;
                door_lock_d = !drained_seen_d;
                drain_d     = !drained_seen_d;
            end
            default: begin
                door_lock_d = 1'b0;
            end
        endcase
        // The soap-phase FILL is the only working state before detergent.
        soap_d  = is_active(state_d) && !((state_d == S_FILL) && (phase_d == PH_SOAP));
        water_d = is_active(state_d) && (phase_d == PH_RINSE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            phase_q        <= PH_SOAP;
            wash_time_q    <= '0;
            rinse_time_q   <= '0;
            spin_time_q    <= '0;
            rinses_q       <= '0;
            rinse_cnt_q    <= '0;
            drained_seen_q <= 1'b0;
            door_lock_q    <= 1'b0;
            motor_q        <= 1'b0;
            fill_q         <= 1'b0;
            drain_q        <= 1'b0;
            done_q         <= 1'b0;
            soap_q         <= 1'b0;
            water_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            wash_time_q    <= wash_time_d;
            rinse_time_q   <= rinse_time_d;
            spin_time_q    <= spin_time_d;
            rinses_q       <= rinses_d;
            rinse_cnt_q    <= rinse_cnt_d;
            drained_seen_q <= drained_seen_d;
            door_lock_q    <= door_lock_d;
            motor_q        <= motor_d;
            fill_q         <= fill_d;
            drain_q        <= drain_d;
            done_q         <= done_d;
            soap_q         <= soap_d;
            water_q        <= water_d;
            fault_q        <= fault_d;
        end
    end

    assign door_lock      = door_lock_q;
    assign motor_on       = motor_q;
    assign fill_valve_on  = fill_q;
    assign drain_valve_on = drain_q;
    assign done           = done_q;
    assign soap_wash      = soap_q;
    assign water_wash     = water_q;
    assign fault          = fault_q;
    assign state_o        = state_q;
    assign rinse_cnt      = rinse_cnt_q;

endmodule

// File: tb/tb_iiitb_wm_prog.sv
module tb_iiitb_wm_prog;

    localparam int TW = 16;
    localparam int RW = 2;
    localparam int FT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          door_close, start, pause, filled, detergent_added, drained;
    logic [TW-1:0] cfg_wash_time, cfg_rinse_time, cfg_spin_time;
    logic [RW-1:0] cfg_rinses;
    logic          door_lock, motor_on, fill_valve_on, drain_valve_on;
    logic          done, soap_wash, water_wash, fault;
    logic [2:0]    state_o;
    logic [RW-1:0] rinse_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model: states as plain ints, durations as remaining-cycle budgets.
    int m_st, m_rem, m_budget, m_cnt, in_st;
    int c_wash, c_rinse, c_spin, c_rinses;
    bit m_rph, m_paused, m_dseen;

    iiitb_wm_prog #(.TIMER_W(TW), .RINSE_W(RW), .FILL_TIMEOUT(FT)) dut (
        .clk(clk), .reset_n(reset_n), .door_close(door_close), .start(start),
        .pause(pause), .filled(filled), .detergent_added(detergent_added),
        .drained(drained), .cfg_wash_time(cfg_wash_time),
        .cfg_rinse_time(cfg_rinse_time), .cfg_spin_time(cfg_spin_time),
        .cfg_rinses(cfg_rinses), .door_lock(door_lock), .motor_on(motor_on),
        .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .done(done), .soap_wash(soap_wash), .water_wash(water_wash),
        .fault(fault), .state_o(state_o), .rinse_cnt(rinse_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {state_o, rinse_cnt, door_lock, motor_on, fill_valve_on,
                drain_valve_on, done, soap_wash, water_wash, fault};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic act, lk, mo, fi, dr, dn, so, ww, fa;
        act = (m_st >= 1) && (m_st <= 5);
        lk  = act || (m_st == 7 && !m_dseen);
        mo  = !m_paused && (m_st == 3 || m_st == 5);
        fi  = !m_paused && (m_st == 1);
        dr  = (!m_paused && (m_st == 4 || m_st == 5)) || (m_st == 7 && !m_dseen);
        dn  = (m_st == 6);
        so  = (m_st >= 2 && m_st <= 5) || (m_st == 1 && m_rph);
        ww  = act && m_rph;
        fa  = (m_st == 7);
        return {3'(m_st), 2'(m_cnt), lk, mo, fi, dr, dn, so, ww, fa};
    endfunction

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_budget = 0; m_cnt = 0; in_st = 0;
        c_wash = 0; c_rinse = 0; c_spin = 0; c_rinses = 0;
        m_rph = 0; m_paused = 0; m_dseen = 0;
    endtask

    task automatic m_enter(input int s);
        m_st = s;
        if (s == 1 || s == 4) m_budget = FT + 1;
        if (s == 0) begin m_cnt = 0; m_rph = 0; end
        if (s == 7) m_dseen = 0;
    endtask

    task automatic model_step();
        m_paused = 0;
        if (m_st >= 1 && m_st <= 5 && pause) begin
            m_paused = 1;
            return;
        end
        case (m_st)
            0: if (start && door_close) begin
                   c_wash = int'(cfg_wash_time); c_rinse = int'(cfg_rinse_time);
                   c_spin = int'(cfg_spin_time); c_rinses = int'(cfg_rinses);
                   m_cnt = 0; m_rph = 0; m_enter(1);
               end
            1: if (filled) begin
                   if (m_rph) begin m_rem = c_rinse + 1; m_enter(3); end
                   else m_enter(2);
               end else begin
                   m_budget--; if (m_budget == 0) m_enter(7);
               end
            2: if (detergent_added) begin m_rem = c_wash + 1; m_enter(3); end
            3: begin m_rem--; if (m_rem == 0) m_enter(4); end
            4: if (drained) begin
                   if (m_cnt < c_rinses) begin m_cnt++; m_rph = 1; m_enter(1); end
                   else begin m_rem = c_spin + 1; m_enter(5); end
               end else begin
                   m_budget--; if (m_budget == 0) m_enter(7);
               end
            5: begin m_rem--; if (m_rem == 0) m_enter(6); end
            6: if (!start) m_enter(0);
            7: begin
                   if (drained) m_dseen = 1;
                   if (drained && !start) m_enter(0);
               end
            default: m_enter(0);
        endcase
    endtask

    task automatic tick();
        int prev;
        prev = m_st;
        @(posedge clk);
        model_step();
        if (m_st != prev) in_st = 0; else in_st++;
        #1;
    endtask

    task automatic auto_sensors(input int dly);
        filled          = (m_st == 1) && (in_st >= dly);
        detergent_added = (m_st == 2) && (in_st >= dly);
        drained         = (m_st == 4) && (in_st >= dly);
    endtask

    task automatic set_cfg(input int w, input int r, input int s, input int n);
        cfg_wash_time = TW'(w); cfg_rinse_time = TW'(r);
        cfg_spin_time = TW'(s); cfg_rinses = RW'(n);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 0; door_close = 0; pause = 0;
        filled = 0; detergent_added = 0; drained = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_cfg(0, 0, 0, 0);
        do_reset();
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_vec got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_full_programme();
        int seq[$];
        int want[$];
        int motor_n, spin_n, last, got;
        want = '{1, 2, 3, 4, 1, 3, 4, 1, 3, 4, 5, 6};
        motor_n = 0; spin_n = 0; last = 0;
        do_reset();
        set_cfg(5, 3, 4, 2); door_close = 1; start = 1;
        for (int c = 0; c < 300 && m_st != 6; c++) begin
            tick(); auto_sensors(0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL full_vec t=%0t got=%h want=%h", $time, dut_vec(), exp_vec());
            end
            if (int'(state_o) != last) begin last = int'(state_o); seq.push_back(last); end
            if (motor_on) motor_n++;
            if (state_o == 3'd5 && motor_on && drain_valve_on) spin_n++;
        end
        total++;
        if (state_o !== 3'd6) begin bad++; $display("FAIL full_timeout state=%0d want=6", state_o); end
        for (int i = 0; i < want.size(); i++) begin
            got = (i < seq.size()) ? seq[i] : -1;
            total++;
            if (got != want[i]) begin bad++; $display("FAIL full_seq[%0d] got=%0d want=%0d", i, got, want[i]); end
        end
        total++;
        if (motor_n != 19) begin bad++; $display("FAIL full_motor_cycles got=%0d want=19", motor_n); end
        total++;
        if (spin_n != 5) begin bad++; $display("FAIL full_spin_cycles got=%0d want=5", spin_n); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (done !== 1'b1 || rinse_cnt !== 2'd2) begin
                bad++; $display("FAIL full_done_hold done=%b rinse_cnt=%0d want 1/2", done, rinse_cnt);
            end
        end
        start = 0; tick();
        total++;
        if (state_o !== 3'd0 || dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL full_to_idle got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_no_rinse();
        int fills;
        bit ww_seen, cnt_seen;
        fills = 0; ww_seen = 0; cnt_seen = 0;
        do_reset();
        set_cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), 0);
        door_close = 1; start = 1;
        for (int c = 0; c < 300 && m_st != 6; c++) begin
            tick(); auto_sensors($urandom_range(0, 3));
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL norinse_vec t=%0t got=%h want=%h", $time, dut_vec(), exp_vec());
            end
            if (water_wash) ww_seen = 1;
            if (rinse_cnt != 0) cnt_seen = 1;
            if (state_o == 3'd1 && in_st == 0) fills++;
        end
        total++;
        if (state_o !== 3'd6) begin bad++; $display("FAIL norinse_timeout state=%0d want=6", state_o); end
        total++;
        if (ww_seen || cnt_seen || fills != 1) begin
            bad++; $display("FAIL norinse_flags water=%b cnt=%b fills=%0d want 0/0/1", ww_seen, cnt_seen, fills);
        end
        start = 0; tick();
    endtask

    task automatic test_pause();
        int motor_n;
        motor_n = 0;
        do_reset();
        set_cfg(5, 0, 0, 0); door_close = 1; start = 1;
        for (int c = 0; c < 50 && !(m_st == 3 && in_st == 2); c++) begin
            tick(); auto_sensors(0);
            if (state_o == 3'd3 && motor_on) motor_n++;
        end
        pause = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (motor_on !== 1'b0 || state_o !== 3'd3 || door_lock !== 1'b1 || dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL pause_hold motor=%b state=%0d got=%h want=%h", motor_on, state_o, dut_vec(), exp_vec());
            end
        end
        pause = 0;
        for (int c = 0; c < 100 && m_st != 6; c++) begin
            tick(); auto_sensors(0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL pause_vec t=%0t got=%h want=%h", $time, dut_vec(), exp_vec());
            end
            if (state_o == 3'd3 && motor_on) motor_n++;
        end
        total++;
        if (motor_n != 6) begin bad++; $display("FAIL pause_motor_cycles got=%0d want=6", motor_n); end
        start = 0; tick();
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        set_cfg(1, 1, 1, 1); door_close = 1; start = 1;
        n = 0;
        tick();
        while (state_o == 3'd1 && n < 50) begin n++; tick(); end
        total++;
        if (n != 9 || state_o !== 3'd7) begin
            bad++; $display("FAIL wd_fill_cycles got=%0d state=%0d want 9/7", n, state_o);
        end
        total++;
        if (fault !== 1'b1 || drain_valve_on !== 1'b1 || door_lock !== 1'b1 || dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL wd_fault_outputs got=%h want=%h", dut_vec(), exp_vec());
        end
        drained = 1; tick();
        total++;
        if (door_lock !== 1'b0 || drain_valve_on !== 1'b0 || fault !== 1'b1 || state_o !== 3'd7) begin
            bad++; $display("FAIL wd_drained lock=%b drain=%b fault=%b state=%0d want 0/0/1/7", door_lock, drain_valve_on, fault, state_o);
        end
        start = 0; tick();
        total++;
        if (state_o !== 3'd0 || fault !== 1'b0 || dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL wd_exit state=%0d fault=%b want 0/0", state_o, fault);
        end
        drained = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cfg(1, 1, 20, 1); door_close = 1; start = 1;
        for (int c = 0; c < 100 && !(m_st == 5 && in_st == 2); c++) begin
            tick(); auto_sensors(0);
        end
        total++;
        if (state_o !== 3'd5 || rinse_cnt !== 2'd1) begin
            bad++; $display("FAIL areset_precond state=%0d rinse_cnt=%0d want 5/1", state_o, rinse_cnt);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 14'd0) begin bad++; $display("FAIL areset_outputs got=%h want=0", dut_vec()); end
        start = 0; filled = 0; detergent_added = 0; drained = 0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        total++;
        if (state_o !== 3'd0 || rinse_cnt !== 2'd0 || dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL areset_release got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_door_open();
        do_reset();
        set_cfg(2, 2, 2, 1); door_close = 0; start = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (state_o !== 3'd0 || dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL door_open state=%0d want=0", state_o);
            end
        end
        start = 0;
    endtask

    task automatic test_cfg_change();
        int agi_n, spin_n;
        agi_n = 0; spin_n = 0;
        do_reset();
        set_cfg(5, 0, 0, 0); door_close = 1; start = 1;
        for (int c = 0; c < 200 && m_st != 6; c++) begin
            tick(); auto_sensors(0);
            if (m_st == 3 && in_st == 1) set_cfg(20, 9, 30, 3);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL cfgchg_vec t=%0t got=%h want=%h", $time, dut_vec(), exp_vec());
            end
            if (state_o == 3'd3 && motor_on) agi_n++;
            if (state_o == 3'd5) spin_n++;
        end
        total++;
        if (agi_n != 6 || spin_n != 1 || rinse_cnt !== 2'd0) begin
            bad++; $display("FAIL cfgchg_latch agi=%0d spin=%0d rinse_cnt=%0d want 6/1/0", agi_n, spin_n, rinse_cnt);
        end
        start = 0; tick();
    endtask

    task automatic test_random();
        int dly;
        bit ended;
        do_reset();
        for (int p = 0; p < 8; p++) begin
            dly = $urandom_range(0, 9);
            ended = 0;
            set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            door_close = 1; start = 1; pause = 0;
            filled = 0; detergent_added = 0; drained = 0;
            for (int c = 0; c < 800; c++) begin
                tick();
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++; $display("FAIL random_vec p=%0d t=%0t got=%h want=%h", p, $time, dut_vec(), exp_vec());
                end
                if (m_st == 6 || m_st == 7) ended = 1;
                if (ended && m_st == 0) break;
                if (m_st == 6) begin
                    start = 0;
                end else if (m_st == 7) begin
                    start = 0; filled = 0; detergent_added = 0;
                    drained = ($urandom_range(0, 2) == 0);
                end else begin
                    auto_sensors(dly);
                    pause = ($urandom_range(0, 7) == 0);
                    if (m_st != 0) begin
                        door_close = $urandom_range(0, 1);
                        set_cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 3));
                    end
                end
            end
            total++;
            if (state_o !== 3'd0) begin bad++; $display("FAIL random_timeout p=%0d state=%0d want=0", p, state_o); end
        end
        pause = 0;
    endtask

    initial begin
        test_reset();
        test_full_programme();
        test_no_rinse();
        test_pause();
        test_watchdog();
        test_async_reset();
        test_door_open();
        test_cfg_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
